uart_tx_serializer: RTL
=======================

// Module: uart_tx_serializer
// PURPOSE
//   UART transmit stage directly downstream of the synchronous TX FIFO.
//   - Pops one word from the FIFO whenever it is idle, enabled and the FIFO is non-empty.
//   - Serializes the word onto the tx line: start bit, data LSB-first, optional parity, stop bit(s).
//   - Bit timing comes from a fixed clocks-per-bit divider.
// PARAMETERS
//   DATA_WIDTH    8   data bits per frame; must match the FIFO word width (`DATA_WIDTH)
//   CLKS_PER_BIT  16  clock cycles per serial bit; legal range >= 2
//   PARITY_EN     0   1 = append a parity bit after the data bits
//   PARITY_ODD    0   0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0
//   STOP_BITS     1   number of stop bits; legal values 1 or 2
// PORTS
//   clock         in   1           system clock; all state updates on posedge
//   reset         in   1           asynchronous, active-low reset
//   fifo_data_in  in   DATA_WIDTH  FIFO data_out; valid in the same cycle fifo_read is high
//   fifo_empty    in   1           FIFO empty flag
//   fifo_read     out  1           FIFO pop strobe; exactly one cycle per frame
//   tx_enable     in   1           permits new frames to start
//   tx            out  1           serial line; idle level is 1
//   busy          out  1           high from the cycle after the pop until frame end
//   frame_done    out  1           one-cycle pulse in the cycle after the last stop-bit cycle
// BEHAVIOUR
//   Reset (reset = 0, asynchronous)
//   - Outputs: tx = 1, busy = 0, frame_done = 0, fifo_read = 0.
//   - State IDLE; all counters and shift register cleared.
//   State machine: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE
//   - IDLE:
//     - fifo_read = tx_enable & ~fifo_empty (combinational, IDLE only).
//     - On that edge: capture fifo_data_in into the shift register, compute the parity bit,
//       clear the baud counter and go to START.
//   - START: tx = 0 for CLKS_PER_BIT cycles.
//   - DATA:
//     - tx = shift_reg[0]; shift right once every CLKS_PER_BIT cycles.
//     - Leave after DATA_WIDTH bits.
//   - PARITY: present only if PARITY_EN = 1.
//     - tx = ^data (even) or ~^data (odd), for CLKS_PER_BIT cycles.
//   - STOP:
//     - tx = 1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
//     - frame_done pulses in the first IDLE cycle.
//   Timing
//   - tx is registered. The pop occurs in cycle T; tx falls at the T+1 edge.
//   - Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
//   - Minimum one IDLE cycle between frames. The pop for the next frame can coincide with the
//     frame_done cycle.
//   Counters
//   - Baud counter width: $clog2(CLKS_PER_BIT); wraps from CLKS_PER_BIT-1 to 0 and generates bit_tick.
//   - Bit counter width: $clog2(DATA_WIDTH+1).
//   Boundary conditions
//   - tx_enable dropped mid-frame: the current frame completes; no new pop.
//   - FIFO empty in IDLE: no pop, tx stays 1, busy stays 0.
//   - fifo_empty or fifo_data_in changing mid-frame: ignored; the data is already latched.
//   - Reset mid-frame: tx returns to 1 immediately. The popped word is discarded, with no
//     partial-frame completion and no frame_done pulse.
//   - fifo_read is never asserted while busy = 1 or while reset = 0.
// STRUCTURE
//   Shared defines file:
//   - DATA_WIDTH.
//   - State encodings: IDLE = 3'd0, START = 1, DATA = 2, PARITY = 3, STOP = 4.
//   Sub-module uart_baud_tick:
//   - Clocks-per-bit counter with a synchronous clear input; outputs a one-cycle bit_tick.
//   - Reused by the future RX stage.
//   Top level: FSM, shift register, bit counter and parity logic.
// TESTING (CLKS_PER_BIT = 4 unless stated)
//   1. FIFO holds 8'hA5, tx_enable = 1, no parity
//      -> fifo_read pulses for 1 cycle.
//      -> tx bits, each held for 4 cycles: 0,1,0,1,0,0,1,0,1,1.
//      -> frame_done pulses 40 cycles after tx falls.
//   2. PARITY_EN = 1: 8'hA5 -> parity bit 0 (even), 1 (odd). 8'h07 -> parity bit 1 (even).
//   3. FIFO preloaded with 8'h01, 8'h02, 8'h03
//      -> three frames; exactly one IDLE cycle between frames.
//      -> three fifo_read pulses; then fifo_empty = 1 and tx stays 1.
//   4. tx_enable = 0 with a non-empty FIFO -> no pop, tx = 1. Assert tx_enable -> pop on the next cycle.
//   5. reset = 0 during the DATA state
//      -> tx = 1 and busy = 0 asynchronously; no frame_done.
//      -> after reset release the next FIFO word is sent intact.
//   6. STOP_BITS = 2 -> stop interval of 8 cycles; busy stays high throughout it.

Source files
------------

// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmit path: default frame width and
// the transmit state encoding, so the TX and future RX stages agree.
package uart_tx_serializer_pkg;

  // Default word width; must match the TX FIFO word width.
  localparam int DATA_WIDTH = 8;

  // Default clocks per serial bit.
  localparam int DEFAULT_CLKS_PER_BIT = 16;

  // Transmit state machine encoding.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } txState_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Clocks-per-bit counter. It produces a one-cycle bit tick every CLKS_PER_BIT
// cycles. A synchronous clear restarts the bit period from zero so that a new
// frame always starts on a full bit. Kept generic so the RX stage can reuse it.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  output logic o_bitTick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  assign o_bitTick = (r_count == LAST_COUNT);

  // Count cycles within a bit period, wrapping at the last cycle or on clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_clear || (r_count == LAST_COUNT)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer. Pops one word from the TX FIFO when idle and
// enabled, then sends start bit, data LSB-first, optional parity and the stop
// bit(s). The tx line is registered so it is glitch-free on the pin.
module uart_tx_serializer #(
  parameter int DATA_WIDTH   = uart_tx_serializer_pkg::DATA_WIDTH,
  parameter int CLKS_PER_BIT = uart_tx_serializer_pkg::DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  input  logic                  tx_enable,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);

  import uart_tx_serializer_pkg::*;

  localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_BIT = BIT_CNT_W'(STOP_BITS - 1);
  localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0);
  localparam bit   HAS_PARITY     = (PARITY_EN != 0);

  txState_t r_state;
  txState_t w_stateNext;

  logic [DATA_WIDTH-1:0] r_shiftReg;
  logic [DATA_WIDTH-1:0] w_shiftNext;
  logic [BIT_CNT_W-1:0]  r_bitCnt;
  logic [BIT_CNT_W-1:0]  w_bitCntNext;
  logic                  r_parity;
  logic                  w_parityNext;
  logic                  r_tx;
  logic                  w_txNext;
  logic                  r_frameDone;
  logic                  w_frameDoneNext;
  logic                  w_pop;
  logic                  w_bitTick;
  logic                  w_baudClear;

  // A pop is only allowed from IDLE and never while reset is held.
  assign w_pop       = reset & (r_state == IDLE) & tx_enable & ~fifo_empty;
  assign w_baudClear = (r_state == IDLE);

  assign fifo_read  = w_pop;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_frameDone;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baudTick (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_baudClear),
    .o_bitTick (w_bitTick)
  );

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Datapath registers: shift register, bit counter, parity, tx and done pulse.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shiftReg  <= '0;
      r_bitCnt    <= '0;
      r_parity    <= 1'b0;
      r_tx        <= 1'b1;
      r_frameDone <= 1'b0;
    end else begin
      r_shiftReg  <= w_shiftNext;
      r_bitCnt    <= w_bitCntNext;
      r_parity    <= w_parityNext;
      r_tx        <= w_txNext;
      r_frameDone <= w_frameDoneNext;
    end
  end

  // Next-state and datapath logic; tx is derived from the next state so the
  // registered line changes on the same edge as the state it belongs to.
  always_comb begin
    w_stateNext     = r_state;
    w_shiftNext     = r_shiftReg;
    w_bitCntNext    = r_bitCnt;
    w_parityNext    = r_parity;
    w_frameDoneNext = 1'b0;
    w_txNext        = 1'b1;

    case (r_state)
      IDLE: begin
        if (w_pop) begin
          w_stateNext  = START;
          w_shiftNext  = fifo_data_in;
          w_parityNext = (^fifo_data_in) ^ PARITY_ODD_BIT;
          w_bitCntNext = '0;
        end
      end
      START: begin
        if (w_bitTick) begin
          w_stateNext = DATA;
        end
      end
      DATA: begin
        if (w_bitTick) begin
          w_shiftNext = r_shiftReg >> 1;
          if (r_bitCnt == LAST_DATA_BIT) begin
            w_bitCntNext = '0;
            if (HAS_PARITY) begin
              w_stateNext = PARITY;
            end else begin
              w_stateNext = STOP;
            end
          end else begin
            w_bitCntNext = r_bitCnt + BIT_CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (w_bitTick) begin
          w_stateNext = STOP;
        end
      end
      STOP: begin
        if (w_bitTick) begin
          if (r_bitCnt == LAST_STOP_BIT) begin
            w_stateNext     = IDLE;
            w_bitCntNext    = '0;
            w_frameDoneNext = 1'b1;
          end else begin
            w_bitCntNext = r_bitCnt + BIT_CNT_W'(1);
          end
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase

    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      PARITY:  w_txNext = w_parityNext;
      default: w_txNext = 1'b1;
    endcase
  end

endmodule
